sipo_rr_deserializer_ctrl: RTL and testbench
============================================

# sipo_rr_deserializer_ctrl

Round-robin controller that shares a single serial-to-parallel deserializer among NUM_CH serial sources. It grants one requester at a time, sequences exactly one word of shift cycles from that source, and presents the assembled word with its channel number on a valid/ready output. It sits between the serial front-end lanes and the word-level consumer, replacing per-lane deserializers.

## Interface
- NUM_CH, 4: number of serial requesters (2..16).
- WIDTH, 32: bits per word (2..64).
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_CH  per-channel request; held high until that channel's word is accepted.
- sdata  input  NUM_CH  per-channel serial bit, valid while that channel's grant is high.
- grant  output  NUM_CH  one-hot grant; the granted source presents the next bit each cycle.
- out_data  output  WIDTH  assembled word, MSB first received.
- out_ch  output  $clog2(NUM_CH)  index of the channel that produced out_data.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word when high with out_valid.
- busy  output  1  high in SHIFT or HOLD.
- parity_err  output  1  one-cycle pulse on a dropped word; constant 0 unless SIPO_ARB_PARITY_EN.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE: if any req bit is high, select a channel round-robin, starting at rr_ptr+1 and wrapping modulo NUM_CH. Register grant = onehot(sel), out_ch = sel, rr_ptr = sel, clear the bit counter, and go to SHIFT. If no req is high, stay in IDLE.
- SHIFT: on each edge, shift sdata[out_ch] into the LSB of the shift register, left-shifting, and increment the counter.
  - After NBITS samples, where NBITS = WIDTH (WIDTH+1 with parity), load out_data, set out_valid = 1, clear grant, and go to HOLD.
- Abort: if req[out_ch] is low at an edge in SHIFT, discard the partial word, clear grant, and go to IDLE. rr_ptr keeps its updated value, and out_valid stays 0.
- HOLD: out_valid and out_data remain stable until out_valid && out_ready is sampled high. On that edge, clear out_valid and go to IDLE.
  - The requester must drop req on the edge after acceptance. A req still high in IDLE is treated as a new request.
- Round robin: rr_ptr resets to NUM_CH-1, so channel 0 wins the first arbitration. A continuously requesting channel cannot be served twice while another channel is requesting.
- Counter width: $clog2(WIDTH+2) bits. It never wraps because it clears on entry to SHIFT.
- busy = (state != IDLE).

## Timing
- Reset values: grant 0, out_valid 0, out_data 0, out_ch 0, busy 0, parity_err 0, rr_ptr NUM_CH-1, state IDLE. Reset takes effect immediately in any state; a partial word is lost.
- Let edge E0 be the edge where IDLE samples req. Grant is high from E0 through edge E0+NBITS, covering exactly NBITS sample edges E1..E_NBITS.
- out_valid rises at E_NBITS, the same edge on which grant falls. Minimum req-to-valid latency is NBITS+1 edges.
- Minimum spacing between consecutive grants is NBITS+2 edges: NBITS shift edges, at least one HOLD edge, and one IDLE edge.
- out_ready high at the edge out_valid rises is accepted at the next edge, not the same edge.
- Simultaneous requests at one IDLE edge are resolved purely by rr_ptr order.

## Configuration
- SIPO_ARB_PARITY_EN defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit, so NBITS = WIDTH+1.
  - On a parity mismatch, the word is not presented: out_valid stays 0, parity_err pulses for one cycle at E_NBITS, and the state returns to IDLE.
  - The parity bit is never visible on out_data.
- SIPO_ARB_PARITY_EN undefined: NBITS = WIDTH, no parity bit is shifted, and parity_err is tied 0.

## Test plan
- Single request, parity off, WIDTH=8: req[2]=1 with bits 1,0,1,1,0,0,1,0 -> grant=4'b0100 for 8 cycles; out_valid at E8; out_data=8'hB2; out_ch=2.
- All four req high, out_ready=1: grants occur in order 0,1,2,3. Each source drops req after acceptance and re-raises it. -> Order repeats 0,1,2,3, and the grant gap is exactly NBITS+2 edges.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data and out_ch stay stable, no new grant issues, and the word is accepted on the first edge with out_ready=1.
- Abort: req[1] drops after 3 shift edges -> grant clears next edge, no out_valid, and the next arbitration starts search at channel 2.
- Reset asserted mid-SHIFT at bit 5 -> all outputs go to reset values immediately; after release, channel 0 wins first.
- Parity on, WIDTH=8: data 8'hB2 with parity bit 0 is accepted; the same data with parity bit 1 -> parity_err pulses 1 cycle, no out_valid.

Source files
------------

// File: rtl/sipo_rr_deserializer_ctrl.sv
// sipo_rr_deserializer_ctrl
// Round-robin controller that time-shares one serial-to-parallel shifter
// among NUM_CH serial sources. It grants one requester at a time, shifts
// in one word from that source (MSB first), and presents the word together
// with its channel index on a valid/ready output.
// Optional feature macro: SIPO_ARB_PARITY_EN. When it is defined, each frame
// carries a trailing even-parity bit. A word that fails the parity check is
// dropped and parity_err pulses for one cycle.
module sipo_rr_deserializer_ctrl #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         sdata,
  output logic [NUM_CH-1:0]         grant,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      parity_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_ARB_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [NBITS-2:0]  shreg;
  logic [NBITS-1:0]  frame;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] sel_onehot;
  logic              any_req;
  int unsigned       rr_idx;
`ifdef SIPO_ARB_PARITY_EN
  logic              perr_q;
`endif

  // The frame holds every sample taken so far plus the bit on the wire at this
  // edge. With parity enabled, its LSB is the parity bit and its upper WIDTH
  // bits are the data.
  assign frame = {shreg, sdata[out_ch]};
  assign busy  = (state != ST_IDLE);

`ifdef SIPO_ARB_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Round-robin pick: scan upward from rr_ptr+1, wrapping, and take the first requester.
  always_comb begin
    sel     = rr_ptr;
    any_req = 1'b0;
    rr_idx  = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      rr_idx = (32'(rr_ptr) + i) % NUM_CH;
      if (!any_req && req[CH_W'(rr_idx)]) begin
        any_req = 1'b1;
        sel     = CH_W'(rr_idx);
      end
    end
  end

  // One-hot form of the selected channel, used to load the grant.
  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  // Main controller: arbitrate in IDLE, shift in SHIFT, wait for the consumer in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      bit_cnt   <= '0;
      shreg     <= '0;
`ifdef SIPO_ARB_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
`ifdef SIPO_ARB_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant   <= sel_onehot;
            out_ch  <= sel;
            rr_ptr  <= sel;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!req[out_ch]) begin
            // Requester withdrew: drop the partial word.
            grant <= '0;
            state <= ST_IDLE;
          end else if (bit_cnt == LAST_CNT) begin
            grant <= '0;
`ifdef SIPO_ARB_PARITY_EN
            if (^frame) begin
              perr_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              out_data  <= frame[NBITS-1 -: WIDTH];
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
`else
            out_data  <= frame[NBITS-1 -: WIDTH];
            out_valid <= 1'b1;
            state     <= ST_HOLD;
`endif
          end else begin
            shreg   <= frame[NBITS-2:0];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rr_deserializer_ctrl.sv
// Directed self-checking bench for sipo_rr_deserializer_ctrl (NUM_CH=4, WIDTH=8).
// The parity scenario runs only when SIPO_ARB_PARITY_EN is defined.
module tb_sipo_rr_deserializer_ctrl;

  localparam int NC = 4;
  localparam int W  = 8;
`ifdef SIPO_ARB_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] req;
  logic [NC-1:0] sdata;
  logic [NC-1:0] grant;
  logic [W-1:0]  out_data;
  logic [1:0]    out_ch;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          parity_err;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] words [NC];
  int           bidx [NC];
  int           low_cnt [NC];

  always #5 clk = ~clk;

  sipo_rr_deserializer_ctrl #(.NUM_CH(NC), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .sdata(sdata), .grant(grant),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .parity_err(parity_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic bit_of(input logic [W-1:0] w, input int i);
    if (i < W) return w[W-1-i];
    return ^w;
  endfunction

  task automatic do_reset;
    reset = 1'b1; req = '0; sdata = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drive n bits of a frame on channel ch, one per cycle, starting right after the grant edge.
  task automatic shift_bits(input int ch, input logic [W-1:0] word, input logic pbit,
                            input int n, output int gerr);
    gerr = 0;
    for (int b = 0; b < n; b++) begin
      sdata[ch] = (b < W) ? word[W-1-b] : pbit;
      @(negedge clk);
      if (b + 1 < NBITS && grant !== (NC'(1) << ch)) gerr++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; sdata = '0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", out_data); else passed++;
    checks++; if (out_ch !== 2'd0) $display("FAIL reset_ch: got %0d expected 0", out_ch); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", parity_err); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int gerr;
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", grant); else passed++;
    checks++; if (out_ch !== 2'd2) $display("FAIL single_ch_early: got %0d expected 2", out_ch); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else passed++;
    shift_bits(2, 8'hB2, 1'b0, NBITS, gerr);
    checks++; if (gerr !== 0) $display("FAIL single_grant_hold: got %0d dropouts expected 0", gerr); else passed++;
    checks++; if (grant !== 4'b0000) $display("FAIL single_grant_off: got %b expected 0000", grant); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
    checks++; if (out_data !== 8'hB2) $display("FAIL single_data: got %h expected b2", out_data); else passed++;
    checks++; if (out_ch !== 2'd2) $display("FAIL single_ch: got %0d expected 2", out_ch); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL single_perr: got %b expected 0", parity_err); else passed++;
    out_ready = 1'b1; req = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL single_accept: got %b expected 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int ngr, nwords, cyc, last_cyc, gch;
    logic [NC-1:0] prev_grant;
    do_reset();
    words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h0F; words[3] = 8'h96;
    for (int c = 0; c < NC; c++) begin bidx[c] = 0; low_cnt[c] = 0; end
    ngr = 0; nwords = 0; cyc = 0; last_cyc = 0; prev_grant = '0;
    req = '1; out_ready = 1'b1;
    while (ngr < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (grant !== '0 && prev_grant === '0) begin
        gch = -1;
        for (int c = 0; c < NC; c++) if (grant[c] === 1'b1) gch = c;
        checks++; if (gch != ngr % NC) $display("FAIL rr_order[%0d]: got %0d expected %0d", ngr, gch, ngr % NC); else passed++;
        if (ngr > 0) begin
          checks++; if (cyc - last_cyc != NBITS + 2) $display("FAIL rr_gap[%0d]: got %0d expected %0d", ngr, cyc - last_cyc, NBITS + 2); else passed++;
        end
        last_cyc = cyc;
        ngr++;
        if (gch >= 0) bidx[gch] = 0;
      end
      for (int c = 0; c < NC; c++) begin
        if (low_cnt[c] > 0) begin
          low_cnt[c]--;
          if (low_cnt[c] == 0) req[c] = 1'b1;
        end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_ch !== 2'(nwords % NC)) $display("FAIL rr_word_ch[%0d]: got %0d expected %0d", nwords, out_ch, nwords % NC); else passed++;
        checks++; if (out_data !== words[nwords % NC]) $display("FAIL rr_word_data[%0d]: got %h expected %h", nwords, out_data, words[nwords % NC]); else passed++;
        req[out_ch] = 1'b0;
        low_cnt[out_ch] = 2;
        nwords++;
      end
      for (int c = 0; c < NC; c++) begin
        if (grant[c] === 1'b1) begin
          sdata[c] = bit_of(words[c], bidx[c]);
          bidx[c]++;
        end
      end
      prev_grant = grant;
    end
    checks++; if (ngr != 8) $display("FAIL rr_timeout: got %0d grants expected 8", ngr); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int gerr, serr;
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) $display("FAIL bp_grant: got %b expected 0010", grant); else passed++;
    shift_bits(1, 8'h6D, ^8'h6D, NBITS, gerr);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h6D) $display("FAIL bp_word: got valid %b data %h expected 1 6d", out_valid, out_data); else passed++;
    req[3] = 1'b1;
    serr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h6D || out_ch !== 2'd1 || grant !== '0 || busy !== 1'b1) serr++;
    end
    checks++; if (serr != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", serr); else passed++;
    out_ready = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_accept: got %b expected 0", out_valid); else passed++;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) $display("FAIL bp_next_grant: got %b expected 1000", grant); else passed++;
    checks++; if (out_ch !== 2'd3) $display("FAIL bp_next_ch: got %0d expected 3", out_ch); else passed++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int gerr;
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) $display("FAIL abort_grant: got %b expected 0010", grant); else passed++;
    shift_bits(1, 8'hFF, 1'b0, 3, gerr);
    checks++; if (gerr !== 0) $display("FAIL abort_grant_hold: got %0d dropouts expected 0", gerr); else passed++;
    req[1] = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL abort_grant_off: got %b expected 0000", grant); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL abort_perr: got %b expected 0", parity_err); else passed++;
    req = 4'b0101;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) $display("FAIL abort_next_grant: got %b expected 0100", grant); else passed++;
    checks++; if (out_ch !== 2'd2) $display("FAIL abort_next_ch: got %0d expected 2", out_ch); else passed++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int gerr;
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    shift_bits(3, 8'hA5, ^8'hA5, 5, gerr);
    checks++; if (busy !== 1'b1 || out_ch !== 2'd3) $display("FAIL rmid_pre: got busy %b ch %0d expected 1 3", busy, out_ch); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) $display("FAIL rmid_grant: got %b expected 0000", grant); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else passed++;
    checks++; if (out_ch !== 2'd0) $display("FAIL rmid_ch: got %0d expected 0", out_ch); else passed++;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL rmid_out: got valid %b data %h expected 0 00", out_valid, out_data); else passed++;
    req = 4'b1001;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) $display("FAIL rmid_first_grant: got %b expected 0001", grant); else passed++;
    req = '0;
    @(negedge clk);
  endtask

`ifdef SIPO_ARB_PARITY_EN
  task automatic test_parity;
    int gerr;
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    shift_bits(2, 8'hB2, 1'b0, NBITS, gerr);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2) $display("FAIL par_good_word: got valid %b data %h expected 1 b2", out_valid, out_data); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL par_good_perr: got %b expected 0", parity_err); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL par_accept: got %b expected 0", out_valid); else passed++;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) $display("FAIL par_regrant: got %b expected 0100", grant); else passed++;
    shift_bits(2, 8'hB2, 1'b1, NBITS, gerr);
    checks++; if (parity_err !== 1'b1) $display("FAIL par_bad_perr: got %b expected 1", parity_err); else passed++;
    checks++; if (out_valid !== 1'b0 || grant !== 4'b0000) $display("FAIL par_bad_drop: got valid %b grant %b expected 0 0000", out_valid, grant); else passed++;
    req = '0;
    @(negedge clk);
    checks++; if (parity_err !== 1'b0 || busy !== 1'b0) $display("FAIL par_pulse_end: got perr %b busy %b expected 0 0", parity_err, busy); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef SIPO_ARB_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
